// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add sequencer: state encoding and
// the two 1-bit full-adder cell functions (exact and AproximateAdder).
package serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Exact full adder, returns {cout, s}.
    function automatic logic [1:0] exact_fa(input logic a, input logic b, input logic c);
        logic s_v;
        logic co_v;
        s_v  = a ^ b ^ c;
        co_v = (a & b) | (c & (a ^ b));
        return {co_v, s_v};
    endfunction

    // AproximateAdder cell: carry is the exact majority, sum is its inverse.
    // Wrong sum only for the all-zero and all-one input patterns.
    function automatic logic [1:0] approx_fa(input logic a, input logic b, input logic c);
        logic co_v;
        co_v = (a & b) | (b & c) | (a & c);
        return {co_v, ~co_v};
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bus between the filter control FSM
// (master) and the serial adder (slave).
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl_fa_cell_sel.sv
// One AproximateAdder cell and one exact full adder, with a select that
// chooses which pair of S/Cout results drives the serial datapath.
module AproximateAdder
    import serial_adder_ctrl_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign {cout_o, s_o} = approx_fa(a_i, b_i, cin_i);
endmodule

module fa_cell_sel
    import serial_adder_ctrl_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    input  logic approx_i,
    output logic s_o,
    output logic cout_o
);
    logic ap_s_s;
    logic ap_co_s;
    logic ex_s_s;
    logic ex_co_s;

    AproximateAdder u_apx (
        .a_i    (a_i),
        .b_i    (b_i),
        .cin_i  (cin_i),
        .s_o    (ap_s_s),
        .cout_o (ap_co_s)
    );

    assign {ex_co_s, ex_s_s} = exact_fa(a_i, b_i, cin_i);

    assign s_o    = approx_i ? ap_s_s  : ex_s_s;
    assign cout_o = approx_i ? ap_co_s : ex_co_s;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one full-adder cell reused over WIDTH clocks, LSB first,
// with the low APPROX_BITS positions routed through the AproximateAdder cell.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
    localparam logic [CW:0]    APPROX_L = (CW + 1)'(APPROX_BITS);

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             use_approx_s;
    logic             cell_s_s;
    logic             cell_co_s;
    logic [WIDTH-1:0] s_sh_d;

    assign use_approx_s = ({1'b0, count_q} < APPROX_L);
    assign s_sh_d       = {cell_s_s, s_sh_q[WIDTH-1:1]};

    fa_cell_sel u_cell (
        .a_i      (a_sh_q[0]),
        .b_i      (b_sh_q[0]),
        .cin_i    (carry_q),
        .approx_i (use_approx_s),
        .s_o      (cell_s_s),
        .cout_o   (cell_co_s)
    );

    // Sequencer FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a_in;
                        b_sh_q  <= bus.b_in;
                        carry_q <= bus.cin;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    carry_q <= cell_co_s;
                    s_sh_q  <= s_sh_d;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        // Final bit: publish the result straight from the cell outputs.
                        sum_q   <= s_sh_d;
                        cout_q  <= cell_co_s;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an exact (APPROX_BITS=0) and a partly approximate
// (APPROX_BITS=4) instance share one stimulus stream and are checked against a model.
module tb_serial_adder_ctrl;
    localparam int W = 8;
    localparam int NAP [2] = '{0, 4};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drv_start = 1'b0;
    logic [W-1:0] drv_a = '0;
    logic [W-1:0] drv_b = '0;
    logic drv_cin = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(W)) bus0 ();
    serial_adder_ctrl_if #(.WIDTH(W)) bus4 ();

    assign bus0.start = drv_start;
    assign bus0.a_in  = drv_a;
    assign bus0.b_in  = drv_b;
    assign bus0.cin   = drv_cin;
    assign bus4.start = drv_start;
    assign bus4.a_in  = drv_a;
    assign bus4.b_in  = drv_b;
    assign bus4.cin   = drv_cin;

    serial_adder_ctrl #(.WIDTH(W), .APPROX_BITS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_adder_ctrl #(.WIDTH(W), .APPROX_BITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    logic         act_busy [2];
    logic         act_done [2];
    logic [W-1:0] act_sum  [2];
    logic         act_cout [2];
    assign act_busy[0] = bus0.busy;  assign act_busy[1] = bus4.busy;
    assign act_done[0] = bus0.done;  assign act_done[1] = bus4.done;
    assign act_sum[0]  = bus0.sum;   assign act_sum[1]  = bus4.sum;
    assign act_cout[0] = bus0.cout;  assign act_cout[1] = bus4.cout;

    // Reference: plain integer addition, or per-bit with the approximate rule on the low nap bits.
    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c, input int nap);
        logic [W-1:0] s;
        int cy;
        int t;
        if (nap == 0) return {1'b0, a} + {1'b0, b} + (W+1)'(c);
        s  = '0;
        cy = int'(c);
        for (int i = 0; i < W; i++) begin
            t = int'(a[i]) + int'(b[i]) + cy;
            if (i < nap) begin
                cy   = (t >= 2) ? 1 : 0;
                s[i] = (t < 2);
            end else begin
                s[i] = (t % 2) == 1;
                cy   = t / 2;
            end
        end
        return {(cy == 1), s};
    endfunction

    // Transaction-level timing model: phase = cycles since accept, 0 when idle.
    int           phase    [2] = '{0, 0};
    logic [W:0]   pend     [2] = '{'0, '0};
    logic [W-1:0] exp_sum  [2] = '{'0, '0};
    logic         exp_cout [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                phase[k]    <= 0;
                exp_sum[k]  <= '0;
                exp_cout[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (phase[k] == 0) begin
                    if (drv_start) begin
                        phase[k] <= 1;
                        pend[k]  <= model_add(drv_a, drv_b, drv_cin, NAP[k]);
                    end
                end else if (phase[k] == W + 1) begin
                    phase[k] <= 0;
                end else begin
                    phase[k] <= phase[k] + 1;
                    if (phase[k] == W) begin
                        exp_sum[k]  <= pend[k][W-1:0];
                        exp_cout[k] <= pend[k][W];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, NAP[k], act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("model_busy", k, (W+1)'(act_busy[k]), (W+1)'(phase[k] != 0));
            chk("model_done", k, (W+1)'(act_done[k]), (W+1)'(phase[k] == W + 1));
            chk("model_sum",  k, (W+1)'(act_sum[k]),  (W+1)'(exp_sum[k]));
            chk("model_cout", k, (W+1)'(act_cout[k]), (W+1)'(exp_cout[k]));
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(posedge clk); #2;
        drv_start = 1'b1;
        drv_a     = a;
        drv_b     = b;
        drv_cin   = c;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            drv_start = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ndone;
        int first_done;
        int last_done;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 0, (W+1)'(bus0.busy), 9'h000);
        chk("rst_sum",  1, (W+1)'(bus4.sum),  9'h000);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // 0x35 + 0x4A with an ignored start in cycle 4 and operands changed after capture.
        issue(8'h35, 8'h4A, 1'b0);
        ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #2;
            drv_start = (c == 4);
            if (c == 2) begin drv_a = 8'hAA; drv_b = 8'h55; end
            if (c == 4) drv_a = 8'h00;
            @(negedge clk);
            chk("t1_busy", 0, (W+1)'(bus0.busy), (W+1)'(c <= 9));
            chk("t1_done", 0, (W+1)'(bus0.done), (W+1)'(c == 9));
            if (bus0.done) ndone++;
            if (c >= 9) chk("t1_sum", 0, {bus0.cout, bus0.sum}, 9'h07F);
        end
        chk("t3_one_done", 0, (W+1)'(ndone), 9'd1);

        // Wrap-around with carry-in.
        issue(8'hFF, 8'h01, 1'b1);
        wait_cycles(9);
        @(negedge clk);
        chk("t2_done", 0, (W+1)'(bus0.done), 9'd1);
        chk("t2_sum",  0, {bus0.cout, bus0.sum}, 9'h101);
        wait_cycles(1);

        // Reset in cycle 5 of a run.
        issue(8'h12, 8'h34, 1'b0);
        wait_cycles(5);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_busy", 0, (W+1)'(bus0.busy), 9'd0);
        chk("t4_done", 0, (W+1)'(bus0.done), 9'd0);
        chk("t4_sum",  0, {bus0.cout, bus0.sum}, 9'h000);
        chk("t4_busy", 1, (W+1)'(bus4.busy), 9'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus0.done || bus4.done) ndone++;
        end
        chk("t4_no_done", 0, (W+1)'(ndone), 9'd0);
        issue(8'h35, 8'h4A, 1'b1);
        wait_cycles(9);
        @(negedge clk);
        chk("t4_after", 0, {bus0.cout, bus0.sum}, 9'h080);
        wait_cycles(1);

        // Pins for the approximate cell rule.
        issue(8'h00, 8'h00, 1'b0);
        wait_cycles(9);
        @(negedge clk);
        chk("apx_zero", 1, {bus4.cout, bus4.sum}, 9'h00F);
        chk("exa_zero", 0, {bus0.cout, bus0.sum}, 9'h000);
        issue(8'hFF, 8'hFF, 1'b1);
        wait_cycles(9);
        @(negedge clk);
        chk("apx_ones", 1, {bus4.cout, bus4.sum}, 9'h1F0);
        chk("exa_ones", 0, {bus0.cout, bus0.sum}, 9'h1FF);
        wait_cycles(1);

        // Random operands, checked by the model each cycle.
        for (int i = 0; i < 256; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            wait_cycles(9);
        end
        wait_cycles(1);

        // start held high: accepts every W+2 cycles.
        @(posedge clk); #2;
        drv_start = 1'b1;
        ndone = 0; first_done = -1; last_done = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus0.done) begin
                if (last_done >= 0) chk("t6_gap", 0, (W+1)'(c - last_done), 9'd10);
                if (first_done < 0) first_done = c;
                last_done = c;
                ndone++;
            end
            @(posedge clk); #2;
            drv_a = W'($urandom);
            drv_b = W'($urandom);
        end
        chk("t6_count", 0, (W+1)'(ndone), 9'd4);
        chk("t6_first", 0, (W+1)'(first_done), 9'd9);
        drv_start = 1'b0;
        wait_cycles(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
